// File: rtl/mem_lsu.sv
// Memory-access stage: runs loads/stores over a req/gnt/rvalid bus, extends load data,
// and forwards writeback/CSR fields to mem_wb, stalling upstream while an access is open.
module mem_lsu #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  mem_re_i,
    input  logic                  mem_we_i,
    input  logic [2:0]            mem_op_i,
    input  logic [ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [DATA_WIDTH-1:0] mem_wdata_i,
    input  logic [4:0]            reg_waddr_i,
    input  logic                  reg_we_i,
    input  logic [DATA_WIDTH-1:0] reg_wdata_i,
    input  logic                  csr_we_i,
    input  logic [11:0]           csr_waddr_i,
    input  logic [DATA_WIDTH-1:0] csr_wdata_i,
    output logic [4:0]            reg_waddr_o,
    output logic                  reg_we_o,
    output logic [DATA_WIDTH-1:0] reg_wdata_o,
    output logic                  csr_we_o,
    output logic [11:0]           csr_waddr_o,
    output logic [DATA_WIDTH-1:0] csr_wdata_o,
    output logic                  bus_req_o,
    output logic                  bus_we_o,
    output logic [ADDR_WIDTH-1:0] bus_addr_o,
    output logic [3:0]            bus_be_o,
    output logic [DATA_WIDTH-1:0] bus_wdata_o,
    input  logic                  bus_gnt_i,
    input  logic                  bus_rvalid_i,
    input  logic [DATA_WIDTH-1:0] bus_rdata_i,
    output logic                  stall_o,
    output logic                  misalign_o,
    input  logic                  flush_int_i
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DONE,
        DRAIN
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  rdata_en;
    logic                  is_mem;
    logic                  misaligned;
    logic                  bubble;
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] load_data;

    assign is_mem     = mem_re_i | mem_we_i;
    assign bus_we_o   = mem_we_i;
    assign bus_addr_o = {mem_addr_i[ADDR_WIDTH-1:2], 2'b00};

    // Size decode from funct3[1:0]; the sign bit funct3[2] only matters for loads.
    always_comb begin
        misaligned  = 1'b0;
        bus_be_o    = 4'b1111;
        bus_wdata_o = mem_wdata_i;
        case (mem_op_i[1:0])
            2'b00: begin
                bus_be_o    = 4'b0001 << mem_addr_i[1:0];
                bus_wdata_o = {4{mem_wdata_i[7:0]}};
            end
            2'b01: begin
                misaligned  = mem_addr_i[0];
                bus_be_o    = 4'b0011 << mem_addr_i[1:0];
                bus_wdata_o = {2{mem_wdata_i[15:0]}};
            end
            default: begin
                misaligned  = |mem_addr_i[1:0];
            end
        endcase
    end

    // Upstream holds the instruction while stalled, so the live address selects the lane.
    assign shifted = rdata_q >> {mem_addr_i[1:0], 3'b000};

    always_comb begin
        case (mem_op_i)
            3'b000:  load_data = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
            3'b001:  load_data = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
            3'b100:  load_data = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
            3'b101:  load_data = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
            default: load_data = rdata_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (rdata_en) begin
                rdata_q <= bus_rdata_i;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rdata_en    = 1'b0;
        bubble      = 1'b0;
        stall_o     = 1'b0;
        bus_req_o   = 1'b0;
        misalign_o  = 1'b0;
        reg_waddr_o = reg_waddr_i;
        reg_we_o    = reg_we_i;
        reg_wdata_o = reg_wdata_i;
        csr_we_o    = csr_we_i;
        csr_waddr_o = csr_waddr_i;
        csr_wdata_o = csr_wdata_i;

        case (state_q)
            IDLE: begin
                if (flush_int_i) begin
                    bubble = 1'b1;
                end else if (is_mem) begin
                    bubble = 1'b1;
                    if (misaligned) begin
                        misalign_o = 1'b1;
                    end else begin
                        stall_o = 1'b1;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                bus_req_o = 1'b1;
                stall_o   = 1'b1;
                bubble    = 1'b1;
                if (flush_int_i) begin
                    state_d = (bus_gnt_i && !bus_rvalid_i) ? DRAIN : IDLE;
                end else if (bus_gnt_i) begin
                    if (bus_rvalid_i) begin
                        rdata_en = 1'b1;
                        state_d  = DONE;
                    end else begin
                        state_d  = WAIT;
                    end
                end
            end
            WAIT: begin
                stall_o = 1'b1;
                bubble  = 1'b1;
                if (flush_int_i) begin
                    state_d = bus_rvalid_i ? IDLE : DRAIN;
                end else if (bus_rvalid_i) begin
                    rdata_en = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (flush_int_i) begin
                    bubble = 1'b1;
                end else if (mem_re_i) begin
                    reg_wdata_o = load_data;
                end
            end
            DRAIN: begin
                stall_o = 1'b1;
                bubble  = 1'b1;
                if (bus_rvalid_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                bubble  = 1'b1;
            end
        endcase

        // Reset abandons any access at once, without waiting for the state register.
        if (!rst_i) begin
            stall_o    = 1'b0;
            bus_req_o  = 1'b0;
            misalign_o = 1'b0;
            bubble     = 1'b1;
        end

        if (bubble) begin
            reg_we_o = 1'b0;
            csr_we_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: pass-through, loads/stores, misalignment, flush drain and reset.
module tb_mem_lsu;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        mem_re_i, mem_we_i;
    logic [2:0]  mem_op_i;
    logic [31:0] mem_addr_i, mem_wdata_i;
    logic [4:0]  reg_waddr_i;
    logic        reg_we_i;
    logic [31:0] reg_wdata_i;
    logic        csr_we_i;
    logic [11:0] csr_waddr_i;
    logic [31:0] csr_wdata_i;
    logic [4:0]  reg_waddr_o;
    logic        reg_we_o;
    logic [31:0] reg_wdata_o;
    logic        csr_we_o;
    logic [11:0] csr_waddr_o;
    logic [31:0] csr_wdata_o;
    logic        bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic        bus_gnt_i, bus_rvalid_i;
    logic [31:0] bus_rdata_i;
    logic        stall_o, misalign_o, flush_int_i;

    int pass_count  = 0;
    int check_count = 0;

    mem_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .mem_re_i(mem_re_i), .mem_we_i(mem_we_i), .mem_op_i(mem_op_i),
        .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
        .reg_waddr_i(reg_waddr_i), .reg_we_i(reg_we_i), .reg_wdata_i(reg_wdata_i),
        .csr_we_i(csr_we_i), .csr_waddr_i(csr_waddr_i), .csr_wdata_i(csr_wdata_i),
        .reg_waddr_o(reg_waddr_o), .reg_we_o(reg_we_o), .reg_wdata_o(reg_wdata_o),
        .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
        .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i),
        .stall_o(stall_o), .misalign_o(misalign_o), .flush_int_i(flush_int_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic re, input logic we, input logic [2:0] op,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic rwe, input logic [4:0] rwaddr,
                                 input logic [31:0] rwdata);
        mem_re_i    = re;
        mem_we_i    = we;
        mem_op_i    = op;
        mem_addr_i  = addr;
        mem_wdata_i = wdata;
        reg_we_i    = rwe;
        reg_waddr_i = rwaddr;
        reg_wdata_i = rwdata;
    endtask

    task automatic nextCycle();
        @(posedge clk_i);
        #1;
    endtask

    // Load whose grant and response arrive together in the first REQ cycle.
    task automatic runLoad(input string tag, input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] expected);
        applyStimulus(1'b1, 1'b0, op, addr, 32'h0, 1'b1, 5'd9, 32'h0);
        #1;
        checkOutput({tag, "_idle_stall"}, 32'(stall_o), 32'd1);
        nextCycle();
        bus_gnt_i    = 1'b1;
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = rdata;
        nextCycle();
        bus_gnt_i    = 1'b0;
        bus_rvalid_i = 1'b0;
        #1;
        checkOutput({tag, "_done_stall"}, 32'(stall_o), 32'd0);
        checkOutput({tag, "_done_data"}, reg_wdata_o, expected);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    initial begin
        rst_i        = 1'b0;
        flush_int_i  = 1'b0;
        bus_gnt_i    = 1'b0;
        bus_rvalid_i = 1'b0;
        bus_rdata_i  = 32'h0;
        csr_we_i     = 1'b0;
        csr_waddr_i  = 12'h0;
        csr_wdata_i  = 32'h0;
        applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        #2;
        checkOutput("reset_req", 32'(bus_req_o), 32'd0);
        checkOutput("reset_stall", 32'(stall_o), 32'd0);
        checkOutput("reset_reg_we", 32'(reg_we_o), 32'd0);
        #10 rst_i = 1'b1;
        nextCycle();

        // ALU pass-through
        applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b1, 5'd5, 32'h1234);
        csr_we_i    = 1'b1;
        csr_waddr_i = 12'h300;
        csr_wdata_i = 32'hDEAD;
        #1;
        checkOutput("alu_waddr", 32'(reg_waddr_o), 32'd5);
        checkOutput("alu_we", 32'(reg_we_o), 32'd1);
        checkOutput("alu_wdata", reg_wdata_o, 32'h1234);
        checkOutput("alu_csr_we", 32'(csr_we_o), 32'd1);
        checkOutput("alu_csr_addr", 32'(csr_waddr_o), 32'h300);
        checkOutput("alu_stall", 32'(stall_o), 32'd0);
        checkOutput("alu_req", 32'(bus_req_o), 32'd0);
        csr_we_i = 1'b0;

        // LB at 0x103, grant in the second REQ cycle, response one cycle later
        applyStimulus(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 1'b1, 5'd7, 32'h0);
        #1;
        checkOutput("lb_idle_stall", 32'(stall_o), 32'd1);
        checkOutput("lb_idle_bubble", 32'(reg_we_o), 32'd0);
        checkOutput("lb_idle_req", 32'(bus_req_o), 32'd0);
        nextCycle();
        checkOutput("lb_req1", 32'(bus_req_o), 32'd1);
        checkOutput("lb_addr", bus_addr_o, 32'h100);
        checkOutput("lb_be", 32'(bus_be_o), 32'b1000);
        checkOutput("lb_we", 32'(bus_we_o), 32'd0);
        checkOutput("lb_req1_stall", 32'(stall_o), 32'd1);
        nextCycle();
        checkOutput("lb_req2", 32'(bus_req_o), 32'd1);
        checkOutput("lb_req2_stall", 32'(stall_o), 32'd1);
        bus_gnt_i = 1'b1;
        nextCycle();
        bus_gnt_i = 1'b0;
        #1;
        checkOutput("lb_wait_req", 32'(bus_req_o), 32'd0);
        checkOutput("lb_wait_stall", 32'(stall_o), 32'd1);
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 32'h80FF_FF7F;
        nextCycle();
        bus_rvalid_i = 1'b0;
        #1;
        checkOutput("lb_done_stall", 32'(stall_o), 32'd0);
        checkOutput("lb_done_we", 32'(reg_we_o), 32'd1);
        checkOutput("lb_done_waddr", 32'(reg_waddr_o), 32'd7);
        checkOutput("lb_done_data", reg_wdata_o, 32'hFFFF_FF80);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);

        // SH at 0x202 with immediate grant
        applyStimulus(1'b0, 1'b1, 3'b001, 32'h202, 32'h0000_ABCD, 1'b0, 5'd0, 32'h0);
        #1;
        checkOutput("sh_idle_stall", 32'(stall_o), 32'd1);
        nextCycle();
        checkOutput("sh_req", 32'(bus_req_o), 32'd1);
        checkOutput("sh_we", 32'(bus_we_o), 32'd1);
        checkOutput("sh_be", 32'(bus_be_o), 32'b1100);
        checkOutput("sh_wdata", bus_wdata_o, 32'hABCD_ABCD);
        bus_gnt_i = 1'b1;
        nextCycle();
        bus_gnt_i = 1'b0;
        #1;
        checkOutput("sh_wait_stall", 32'(stall_o), 32'd1);
        checkOutput("sh_wait_req", 32'(bus_req_o), 32'd0);
        bus_rvalid_i = 1'b1;
        nextCycle();
        bus_rvalid_i = 1'b0;
        #1;
        checkOutput("sh_done_stall", 32'(stall_o), 32'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);

        // Lane selection and extension, grant and response together
        runLoad("lh", 3'b001, 32'h002, 32'h8001_0000, 32'hFFFF_8001);
        runLoad("lbu", 3'b100, 32'h001, 32'h0000_8000, 32'h0000_0080);
        runLoad("lhu", 3'b101, 32'h002, 32'h8001_0000, 32'h0000_8001);
        runLoad("lw", 3'b010, 32'h004, 32'hCAFE_F00D, 32'hCAFE_F00D);

        // Misaligned LW
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 1'b1, 5'd3, 32'h0);
        #1;
        checkOutput("mis_pulse", 32'(misalign_o), 32'd1);
        checkOutput("mis_req", 32'(bus_req_o), 32'd0);
        checkOutput("mis_reg_we", 32'(reg_we_o), 32'd0);
        checkOutput("mis_stall", 32'(stall_o), 32'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        checkOutput("mis_clear", 32'(misalign_o), 32'd0);
        checkOutput("mis_after_req", 32'(bus_req_o), 32'd0);

        // LHU flushed during WAIT, drained until the late response
        applyStimulus(1'b1, 1'b0, 3'b101, 32'h0, 32'h0, 1'b1, 5'd4, 32'h0);
        nextCycle();
        bus_gnt_i = 1'b1;
        nextCycle();
        bus_gnt_i   = 1'b0;
        flush_int_i = 1'b1;
        #1;
        checkOutput("fl_wait_stall", 32'(stall_o), 32'd1);
        checkOutput("fl_wait_bubble", 32'(reg_we_o), 32'd0);
        nextCycle();
        flush_int_i = 1'b0;
        applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b1, 5'd4, 32'h55);
        #1;
        checkOutput("fl_drain1_stall", 32'(stall_o), 32'd1);
        checkOutput("fl_drain1_bubble", 32'(reg_we_o), 32'd0);
        nextCycle();
        checkOutput("fl_drain2_stall", 32'(stall_o), 32'd1);
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 32'h0000_FFFF;
        #1;
        checkOutput("fl_rvalid_stall", 32'(stall_o), 32'd1);
        checkOutput("fl_rvalid_bubble", 32'(reg_we_o), 32'd0);
        nextCycle();
        bus_rvalid_i = 1'b0;
        #1;
        checkOutput("fl_idle_stall", 32'(stall_o), 32'd0);
        checkOutput("fl_idle_we", 32'(reg_we_o), 32'd1);
        checkOutput("fl_idle_data", reg_wdata_o, 32'h55);

        // Asynchronous reset while in REQ
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 1'b1, 5'd2, 32'h0);
        nextCycle();
        checkOutput("rst_req_before", 32'(bus_req_o), 32'd1);
        rst_i = 1'b0;
        #1;
        checkOutput("rst_req_drop", 32'(bus_req_o), 32'd0);
        checkOutput("rst_stall_drop", 32'(stall_o), 32'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b1, 5'd6, 32'h77);
        rst_i = 1'b1;
        #1;
        checkOutput("rst_pass_data", reg_wdata_o, 32'h77);
        checkOutput("rst_pass_we", 32'(reg_we_o), 32'd1);
        checkOutput("rst_pass_stall", 32'(stall_o), 32'd0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 1'b1, 5'd2, 32'h0);
        #1;
        checkOutput("rst_idle_req", 32'(bus_req_o), 32'd0);
        checkOutput("rst_idle_stall", 32'(stall_o), 32'd1);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
Memory-access stage between the exe_mem pipeline register and mem_wb. It executes RISC-V loads and stores over a req/gnt/rvalid data bus and sign- or zero-extends load data. It forwards register-writeback and CSR fields to mem_wb, and stalls the upstream pipeline while a bus access is outstanding. Non-memory instructions pass through combinationally with zero added latency.

Parameters:
DATA_WIDTH, 32, data bus and register data width (fixed at 32 for this ISA)
ADDR_WIDTH, 32, data bus byte-address width

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-low
mem_re_i  in  1  load instruction present (from exe_mem)
mem_we_i  in  1  store instruction present
mem_op_i  in  3  funct3 size/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU
mem_addr_i  in  ADDR_WIDTH  effective byte address
mem_wdata_i  in  DATA_WIDTH  store data, right-aligned
reg_waddr_i / reg_we_i / reg_wdata_i  in  5/1/DATA_WIDTH  writeback fields; reg_wdata_i is the ALU result
csr_we_i / csr_waddr_i / csr_wdata_i  in  1/12/DATA_WIDTH  CSR fields
reg_waddr_o / reg_we_o / reg_wdata_o  out  5/1/DATA_WIDTH  to mem_wb
csr_we_o / csr_waddr_o / csr_wdata_o  out  1/12/DATA_WIDTH  to mem_wb
bus_req_o  out  1  bus request
bus_we_o  out  1  write request
bus_addr_o  out  ADDR_WIDTH  word-aligned address ({addr[31:2],2'b00})
bus_be_o  out  4  byte enables
bus_wdata_o  out  DATA_WIDTH  lane-replicated store data
bus_gnt_i  in  1  request accepted this cycle
bus_rvalid_i  in  1  response valid (reads and writes)
bus_rdata_i  in  DATA_WIDTH  read data
stall_o  out  1  hold upstream stages
misalign_o  out  1  one-cycle misaligned-access pulse to interrupt ctrl
flush_int_i  in  1  pipeline flush from interrupt ctrl

Behaviour:
- FSM states: IDLE, REQ, WAIT, DONE, DRAIN. Reset puts the FSM in IDLE and clears the load register; all registered outputs go to 0.
- IDLE, no mem op: outputs equal inputs combinationally; stall_o=0; bus_req_o=0.
- IDLE, mem op, aligned, no flush: go to REQ. This cycle: stall_o=1 and bubble (reg_we_o=0, csr_we_o=0).
- Alignment rule: H/HU needs addr[0]=0; W needs addr[1:0]=0. A misaligned access raises misalign_o for one cycle, issues no bus access, outputs a bubble, holds stall_o=0, and stays in IDLE.
- REQ: bus_req_o=1 with stable addr/we/be/wdata until bus_gnt_i. On gnt, go to WAIT. If bus_rvalid_i arrives in the same cycle as gnt, go directly to DONE (capture data). stall_o=1, bubble.
- WAIT: stall_o=1, bubble. On bus_rvalid_i, latch bus_rdata_i and go to DONE.
- DONE (one cycle): stall_o=0. Writeback fields pass through, except that for loads reg_wdata_o is the extended latched data. Return to IDLE; upstream advances this same cycle.
- Byte enables: B = 0001<<addr[1:0]. H = 0011<<addr[1:0]. W = 1111.
- Store data: B replicates wdata[7:0] x4; H replicates wdata[15:0] x2.
- Load extract: select the lane by addr[1:0]. B and H sign-extend; BU and HU zero-extend.
- Flush in IDLE or DONE: bubble outputs; FSM goes to (or stays in) IDLE.
- Flush in REQ before gnt: drop the request and go to IDLE.
- Flush in REQ with gnt, or in WAIT: go to DRAIN. DRAIN holds stall_o=1 with bubble outputs until bus_rvalid_i, discards the data, then goes to IDLE. A store already granted completes on the bus.
- Flush has priority over every other event in the same cycle.
- Async reset mid-access abandons the bus transaction; bus_req_o drops immediately.

Test Plan:
- ALU op: reg_we_i=1, waddr=5, wdata=0x1234, no mem op -> same-cycle outputs 5/1/0x1234, stall_o=0, bus_req_o=0.
- LB at addr 0x103, gnt after 2 cycles, rvalid 1 cycle later with rdata=0x80FF_FF7F -> bus_be_o=1000 and addr 0x100; stall_o high for 4 cycles; DONE cycle gives reg_wdata_o=0xFFFF_FF80.
- SH at 0x202, wdata 0x0000_ABCD, immediate gnt -> be=1100, bus_wdata_o=0xABCD_ABCD, bus_we_o=1; single-cycle stall before rvalid, then DONE.
- LW at 0x101 -> misalign_o=1 for one cycle, no bus_req_o, reg_we_o=0, stall_o=0.
- LHU at 0x0, flush_int_i during WAIT, rvalid 3 cycles later with 0xFFFF -> DRAIN keeps stall_o=1 and reg_we_o=0 until rvalid, then IDLE; no writeback of 0xFFFF.
- Reset (rst_i=0) asserted while in REQ -> bus_req_o and stall_o fall asynchronously; after release, FSM is in IDLE and pass-through works.
